// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-cache stalls,
// with a MEM_WAIT watchdog. Optional performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] IF_ID_RS1addr_i,
    input  logic [4:0] IF_ID_RS2addr_i,
    input  logic [4:0] ID_EX_RDaddr_i,
    input  logic       ID_EX_MemRead_i,
    input  logic       Branch_taken_i,
    input  logic       DCache_stall_i,
    output logic       PC_write_o,
    output logic       IF_ID_write_o,
    output logic       NoOp_o,
    output logic       IF_ID_flush_o,
    output logic       pipe_stall_o,
    output logic [1:0] state_o,
    output logic       timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] load_use_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        BUBBLE   = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic              load_use;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              timeout_q;

    assign load_use = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                      ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) ||
                       (ID_EX_RDaddr_i == IF_ID_RS2addr_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // MEM_WAIT without a stall decodes exactly like RUN; only BUBBLE masks load_use.
    always_comb begin
        next_state    = RUN;
        PC_write_o    = 1'b1;
        IF_ID_write_o = 1'b1;
        NoOp_o        = 1'b0;
        IF_ID_flush_o = 1'b0;
        pipe_stall_o  = 1'b0;
        if (DCache_stall_i) begin
            pipe_stall_o  = 1'b1;
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            next_state    = MEM_WAIT;
        end else if ((state != BUBBLE) && load_use) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            NoOp_o        = 1'b1;
            next_state    = BUBBLE;
        end else if (Branch_taken_i) begin
            IF_ID_flush_o = 1'b1;
        end
    end

    assign state_o   = state;
    assign timeout_o = timeout_q;
    assign wait_inc  = (wait_cnt == TIMEOUT_V) ? wait_cnt : wait_cnt + 1'b1;

    // The counter counts completed MEM_WAIT cycles, so the flag rises after the TIMEOUT-th one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state == MEM_WAIT) begin
            wait_cnt <= wait_inc;
            if (wait_inc == TIMEOUT_V) begin
                timeout_q <= 1'b1;
            end
        end else if (next_state == MEM_WAIT) begin
            wait_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_use_cnt_o  <= '0;
            mem_stall_cnt_o <= '0;
            flush_cnt_o     <= '0;
        end else begin
            if ((next_state == BUBBLE) && (load_use_cnt_o != CNT_MAX)) begin
                load_use_cnt_o <= load_use_cnt_o + 1'b1;
            end
            if ((state == MEM_WAIT) && (mem_stall_cnt_o != CNT_MAX)) begin
                mem_stall_cnt_o <= mem_stall_cnt_o + 1'b1;
            end
            if (IF_ID_flush_o && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule
